mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 36 +++
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit_load_extend.sv | 35 +++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: access size, fault cause and FSM state.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_TIMEOUT  = 2'd2,
        FC_ILLEGAL  = 2'd3
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Address bits that must be zero for an access of this size to be aligned.
    function automatic logic [2:0] size_low_mask(input logic [1:0] size);
        logic [3:0] m;
        m = size_bytes(size) - 4'd1;
        return m[2:0];
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the access unit; the unit is the master, the memory the slave.
interface mem_access_unit_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
);
    import mem_access_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks 2^size bytes at a lane offset from a read word and sign/zero extends them.
module load_extend
    import mem_access_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  logic [1:0]       size,
    input  logic             unsigned_ld,
    output logic [XLEN-1:0]  result
);

    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] mask;
    logic            msb;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        if (size_bytes(size) >= 4'(XLEN / 8)) begin
            mask = '1;
        end else begin
            mask = ~({XLEN{1'b1}} << (7'd8 << size));
        end
        // mask ^ (mask >> 1) isolates the top bit of the lane
        msb = |(lane & (mask ^ (mask >> 1)));
        if (&mask) begin
            result = lane;
        end else begin
            result = (lane & mask) | ((!unsigned_ld && msb) ? ~mask : '0);
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine with read-modify-write for partial stores.
// Build option: MEM_ACCESS_MISALIGN_EXC_EN faults misaligned accesses instead of aligning them down.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op_load,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   load_data,
    output logic              fault,
    output logic [1:0]        fault_cause,
    mem_access_unit_if.master mem
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    fault_cause_e      cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_clr, cnt_inc, latch_req, rd_ack;

    logic              illegal_sz, misaligned, full_width;
    logic [2:0]        low_mask;
    logic [ADDR_W-1:0] eff_addr;

    logic              r_load, r_uns;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [XLEN-1:0]   r_sdata;
    logic [XLEN-1:0]   load_q, wdata_q, ext_result, lane_mask, merged;
    logic [ADDR_W-1:0] maddr_q;

    always_comb begin
        low_mask   = size_low_mask(size);
        illegal_sz = (XLEN == 32) && (size == SZ_DOUBLE);
        full_width = (size_bytes(size) == 4'(XLEN / 8));
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        misaligned = |(addr[2:0] & low_mask);
        eff_addr   = addr;
`else
        misaligned = 1'b0;
        eff_addr   = addr & ~ADDR_W'(low_mask);
`endif
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        latch_req = 1'b0;
        rd_ack    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_req = 1'b1;
                    cnt_clr   = 1'b1;
                    cause_d   = FC_NONE;
                    if (illegal_sz) begin
                        state_d = ST_DONE;
                        cause_d = FC_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = ST_DONE;
                        cause_d = FC_MISALIGN;
                    end else if (!op_load && full_width) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD, ST_WR: begin
                if (mem.mem_ack) begin
                    cnt_clr = 1'b1;
                    rd_ack  = (state_q == ST_RD);
                    state_d = (state_q == ST_RD && !r_load) ? ST_WR : ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cause_d = FC_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cause_q <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Partial store: replace only the addressed bytes of the word just read.
    always_comb begin
        if (size_bytes(r_size) >= 4'(XLEN / 8)) begin
            lane_mask = '1;
        end else begin
            lane_mask = ~({XLEN{1'b1}} << (7'd8 << r_size));
        end
        merged = (mem.mem_rdata & ~(lane_mask << {r_off, 3'b000}))
               | ((r_sdata & lane_mask) << {r_off, 3'b000});
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata       (mem.mem_rdata),
        .offset      (r_off),
        .size        (r_size),
        .unsigned_ld (r_uns),
        .result      (ext_result)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_load  <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= '0;
            r_off   <= '0;
            r_sdata <= '0;
            load_q  <= '0;
            wdata_q <= '0;
            maddr_q <= '0;
        end else begin
            if (latch_req) begin
                r_load  <= op_load;
                r_uns   <= unsigned_ld;
                r_size  <= size;
                r_off   <= eff_addr[OFF_W-1:0];
                r_sdata <= store_data;
                maddr_q <= {eff_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                wdata_q <= store_data;
            end
            if (rd_ack) begin
                if (r_load) begin
                    load_q <= ext_result;
                end else begin
                    wdata_q <= merged;
                end
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign fault         = done && (cause_q != FC_NONE);
    assign fault_cause   = done ? cause_q : FC_NONE;
    assign load_data     = load_q;
    assign mem.mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
    assign mem.mem_we    = (state_q == ST_WR);
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random load/store traffic against a byte-level memory model, plus
// directed cases (timeout, reset mid-access, illegal size on a 32-bit instance).
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start, op_load, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [63:0] store_data;
    logic        busy, done, fault;
    logic [63:0] load_data;
    logic [1:0]  fault_cause;

    logic        st32, ld32, un32, by32, dn32, f32;
    logic [1:0]  sz32, fc32;
    logic [31:0] ad32, sd32, ldd32;

    mem_access_unit_if #(.XLEN(64), .ADDR_W(32)) mif ();
    mem_access_unit_if #(.XLEN(32), .ADDR_W(32)) mif32 ();

    mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .start(start), .op_load(op_load), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .store_data(store_data), .busy(busy),
        .done(done), .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
        .mem(mif)
    );

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(255)) dut32 (
        .clock(clock), .reset(reset), .start(st32), .op_load(ld32), .size(sz32),
        .unsigned_ld(un32), .addr(ad32), .store_data(sd32), .busy(by32),
        .done(dn32), .load_data(ldd32), .fault(f32), .fault_cause(fc32),
        .mem(mif32)
    );

    always #5 clock = ~clock;

    int unsigned vectors = 0, miscompares = 0;
    int unsigned cyc = 0, req_cycles, done_cnt, done_cyc, last_ack_cyc, rd_count, wr_count;
    int unsigned wait_cnt = 0;
    logic        resp_en;
    logic        first_we;
    logic [63:0] first_wdata, last_wr_data, exp_ld;
    logic [31:0] last_rd_addr, last_wr_addr;
    logic [63:0] mem_model [logic [31:0]];

    function automatic logic [63:0] ref_load(input logic [63:0] w, input int unsigned off,
                                             input int unsigned nb, input logic uns);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < nb; i++) r[8*i +: 8] = w[8*(off+i) +: 8];
        if (!uns && nb < 8 && r[8*nb-1])
            for (int unsigned i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [63:0] ref_merge(input logic [63:0] w, input logic [63:0] sd,
                                              input int unsigned off, input int unsigned nb);
        logic [63:0] r;
        r = w;
        for (int unsigned i = 0; i < nb; i++) r[8*(off+i) +: 8] = sd[8*i +: 8];
        return r;
    endfunction

    // Memory responder and bus monitor, both evaluated on the falling edge.
    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (mif.mem_req === 1'b1) begin
                if (req_cycles == 0) begin
                    first_we    = mif.mem_we;
                    first_wdata = mif.mem_wdata;
                end
                req_cycles++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mif.mem_ack) begin
                mif.mem_ack = 1'b0;
                wait_cnt    = $urandom_range(0, 2);
            end else if (resp_en && mif.mem_req === 1'b1) begin
                if (wait_cnt == 0) begin
                    mif.mem_ack  = 1'b1;
                    last_ack_cyc = cyc;
                    if (mif.mem_we) begin
                        wr_count++;
                        last_wr_addr = mif.mem_addr;
                        last_wr_data = mif.mem_wdata;
                    end else begin
                        rd_count++;
                        last_rd_addr  = mif.mem_addr;
                        mif.mem_rdata = mem_model.exists(mif.mem_addr) ? mem_model[mif.mem_addr] : 64'h0;
                    end
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic clear_mon;
        req_cycles = 0; done_cnt = 0; rd_count = 0; wr_count = 0;
        first_we = 1'b0; first_wdata = '0; done_cyc = 0; last_ack_cyc = 0;
    endtask

    task automatic run_op(input logic ld, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [63:0] sd);
        int unsigned nb, off, n;
        logic [31:0] ea, wa;
        logic        exp_acc, exp_rd, exp_wr, got_f;
        logic [1:0]  exp_cause, got_c;
        logic [63:0] exp_w, got_ld;
        nb = 1 << sz;
        exp_cause = 2'd0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        ea = a;
        if ((a % nb) != 0) exp_cause = 2'd1;
`else
        ea = a - (a % nb);
`endif
        off = ea % 8;
        wa  = ea - off;
        exp_acc = (exp_cause == 2'd0);
        exp_wr  = exp_acc && !ld;
        exp_rd  = exp_acc && (ld || nb != 8);
        if (exp_rd && !mem_model.exists(wa)) mem_model[wa] = {$urandom, $urandom};
        exp_w = sd;
        if (exp_wr && nb != 8) exp_w = ref_merge(mem_model[wa], sd, off, nb);
        if (exp_acc && ld) exp_ld = ref_load(mem_model[wa], off, nb, uns);

        @(negedge clock); #1;
        clear_mon();
        start = 1'b1; op_load = ld; size = sz; unsigned_ld = uns; addr = a; store_data = sd;
        @(negedge clock);
        start = 1'b0;
        op_load = $urandom; size = $urandom; addr = $urandom; store_data = {$urandom, $urandom};
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clock); n++; end
        got_ld = load_data; got_f = fault; got_c = fault_cause;
        @(negedge clock); #1;
        if (exp_wr) mem_model[wa] = exp_w;

        vectors++; if (n >= 40) begin miscompares++; $display("FAIL done_wait: got no done in %0d cycles, expected done", n); end
        vectors++; if (got_f !== !exp_acc) begin miscompares++; $display("FAIL fault: got %b expected %b", got_f, !exp_acc); end
        vectors++; if (got_c !== exp_cause) begin miscompares++; $display("FAIL fault_cause: got %0d expected %0d", got_c, exp_cause); end
        vectors++; if (got_ld !== exp_ld) begin miscompares++; $display("FAIL load_data a=%h sz=%0d: got %h expected %h", a, sz, got_ld, exp_ld); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL done_pulse: got %0d cycles expected 1", done_cnt); end
        vectors++; if (busy !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'd0) begin miscompares++; $display("FAIL idle_after: got busy=%b fault=%b cause=%0d expected 0", busy, fault, fault_cause); end
        vectors++; if (rd_count != int'(exp_rd)) begin miscompares++; $display("FAIL read_count: got %0d expected %0d", rd_count, exp_rd); end
        vectors++; if (wr_count != int'(exp_wr)) begin miscompares++; $display("FAIL write_count: got %0d expected %0d", wr_count, exp_wr); end
        if (exp_acc) begin
            vectors++; if (done_cyc != last_ack_cyc + 1) begin miscompares++; $display("FAIL latency: got done at %0d expected %0d", done_cyc, last_ack_cyc + 1); end
        end else begin
            vectors++; if (req_cycles != 0) begin miscompares++; $display("FAIL no_req: got %0d req cycles expected 0", req_cycles); end
        end
        if (exp_rd) begin
            vectors++; if (last_rd_addr !== wa) begin miscompares++; $display("FAIL rd_addr: got %h expected %h", last_rd_addr, wa); end
        end
        if (exp_wr) begin
            vectors++; if (last_wr_addr !== wa) begin miscompares++; $display("FAIL wr_addr: got %h expected %h", last_wr_addr, wa); end
            vectors++; if (last_wr_data !== exp_w) begin miscompares++; $display("FAIL wdata a=%h sz=%0d: got %h expected %h", a, sz, last_wr_data, exp_w); end
            vectors++; if (first_we !== (nb == 8)) begin miscompares++; $display("FAIL first_we: got %b expected %b", first_we, nb == 8); end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_ctl: got busy=%b done=%b expected 0", busy, done); end
        vectors++; if (fault !== 1'b0 || fault_cause !== 2'd0) begin miscompares++; $display("FAIL reset_fault: got %b/%0d expected 0", fault, fault_cause); end
        vectors++; if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_req: got req=%b we=%b expected 0", mif.mem_req, mif.mem_we); end
        vectors++; if (load_data !== 64'h0 || mif.mem_addr !== 32'h0 || mif.mem_wdata !== 64'h0) begin miscompares++; $display("FAIL reset_data: got %h %h %h expected 0", load_data, mif.mem_addr, mif.mem_wdata); end
        reset = 1'b1;
    endtask

    task automatic test_directed;
        mem_model[32'h100] = 64'h0000_0000_8000_0000;
        run_op(1'b1, 2'd0, 1'b0, 32'h103, 64'h0);
        vectors++; if (load_data !== 64'hFFFF_FFFF_FFFF_FF80) begin miscompares++; $display("FAIL lb_sign: got %h expected ffffffffffffff80", load_data); end
        run_op(1'b1, 2'd0, 1'b1, 32'h103, 64'h0);
        vectors++; if (load_data !== 64'h80) begin miscompares++; $display("FAIL lbu: got %h expected 80", load_data); end
        mem_model[32'h100] = 64'h1122_3344_5566_7788;
        run_op(1'b0, 2'd1, 1'b0, 32'h106, 64'hABCD);
        vectors++; if (last_wr_data !== 64'hABCD_3344_5566_7788 || last_wr_addr !== 32'h100) begin miscompares++; $display("FAIL sh_merge: got %h @%h expected abcd334455667788 @100", last_wr_data, last_wr_addr); end
        run_op(1'b0, 2'd3, 1'b0, 32'h108, 64'hDEAD_BEEF_0123_4567);
        vectors++; if (rd_count != 0 || first_we !== 1'b1 || first_wdata !== 64'hDEAD_BEEF_0123_4567) begin miscompares++; $display("FAIL sd_direct: got rd=%0d we=%b wdata=%h expected 0/1/deadbeef01234567", rd_count, first_we, first_wdata); end
        run_op(1'b1, 2'd2, 1'b0, 32'h102, 64'h0);
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        vectors++; if (req_cycles != 0) begin miscompares++; $display("FAIL lw_misalign: got %0d req cycles expected 0", req_cycles); end
`else
        vectors++; if (last_rd_addr !== 32'h100 || load_data !== 64'h0000_0000_5566_7788) begin miscompares++; $display("FAIL lw_align: got %h @%h expected 55667788 @100", load_data, last_rd_addr); end
`endif
    endtask

    task automatic test_random;
        for (int k = 0; k < 60; k++)
            run_op(1'($urandom), 2'($urandom), 1'($urandom), 32'h100 + $urandom_range(0, 255), {$urandom, $urandom});
    endtask

    task automatic test_timeout;
        int unsigned n;
        resp_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock); #1;
            clear_mon();
            start = 1'b1; op_load = (k == 0); size = (k == 0) ? 2'd2 : 2'd3; addr = 32'h200; store_data = 64'h5A5A;
            @(negedge clock);
            start = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 40) begin @(negedge clock); n++; end
            vectors++; if (fault !== 1'b1 || fault_cause !== 2'd2) begin miscompares++; $display("FAIL timeout_cause: got %b/%0d expected 1/2", fault, fault_cause); end
            vectors++; if (mif.mem_req !== 1'b0 || load_data !== exp_ld) begin miscompares++; $display("FAIL timeout_state: got req=%b ld=%h expected 0/%h", mif.mem_req, load_data, exp_ld); end
            @(negedge clock); #1;
            vectors++; if (req_cycles != 4 || done_cnt != 1) begin miscompares++; $display("FAIL timeout_len: got %0d req / %0d done expected 4/1", req_cycles, done_cnt); end
            vectors++; if (first_we !== (k == 1)) begin miscompares++; $display("FAIL timeout_we: got %b expected %b", first_we, k == 1); end
        end
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        resp_en = 1'b0;
        @(negedge clock); #1;
        clear_mon();
        start = 1'b1; op_load = 1'b1; size = 2'd0; addr = 32'h120;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        vectors++; if (mif.mem_req !== 1'b1) begin miscompares++; $display("FAIL mid_rd: got req=%b expected 1", mif.mem_req); end
        reset = 1'b0;
        @(negedge clock); #1;
        exp_ld = '0;
        vectors++; if (mif.mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got req=%b busy=%b done=%b expected 0", mif.mem_req, busy, done); end
        vectors++; if (load_data !== 64'h0 || mif.mem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_reset_data: got %h @%h expected 0", load_data, mif.mem_addr); end
        reset = 1'b1; resp_en = 1'b1;
        repeat (3) @(negedge clock); #1;
        vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL mid_no_done: got %0d done cycles expected 0", done_cnt); end
        run_op(1'b1, 2'd3, 1'b0, 32'h120, 64'h0);
    endtask

    task automatic test_xlen32;
        int unsigned n, reqs;
        @(negedge clock); #1;
        st32 = 1'b1; ld32 = 1'b0; sz32 = 2'd3; ad32 = 32'h100; sd32 = 32'h1234_5678;
        @(negedge clock);
        st32 = 1'b0; reqs = 0; n = 0;
        while (dn32 !== 1'b1 && n < 20) begin if (mif32.mem_req) reqs++; @(negedge clock); n++; end
        vectors++; if (dn32 !== 1'b1 || f32 !== 1'b1 || fc32 !== 2'd3) begin miscompares++; $display("FAIL illegal_size: got done=%b fault=%b cause=%0d expected 1/1/3", dn32, f32, fc32); end
        vectors++; if (reqs != 0 || mif32.mem_req !== 1'b0) begin miscompares++; $display("FAIL illegal_noreq: got %0d req cycles expected 0", reqs); end
        @(negedge clock); #1;
        st32 = 1'b1; ld32 = 1'b1; sz32 = 2'd1; un32 = 1'b0; ad32 = 32'h102;
        @(negedge clock);
        st32 = 1'b0; n = 0;
        while (mif32.mem_req !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        vectors++; if (mif32.mem_req !== 1'b1 || mif32.mem_we !== 1'b0 || mif32.mem_addr !== 32'h100) begin miscompares++; $display("FAIL lh32_req: got req=%b we=%b @%h expected 1/0 @100", mif32.mem_req, mif32.mem_we, mif32.mem_addr); end
        mif32.mem_rdata = 32'h8001_1234; mif32.mem_ack = 1'b1;
        @(negedge clock);
        mif32.mem_ack = 1'b0;
        vectors++; if (dn32 !== 1'b1 || f32 !== 1'b0 || ldd32 !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh32: got done=%b fault=%b ld=%h expected 1/0/ffff8001", dn32, f32, ldd32); end
        @(negedge clock);
        vectors++; if (by32 !== 1'b0 || dn32 !== 1'b0) begin miscompares++; $display("FAIL lh32_idle: got busy=%b done=%b expected 0", by32, dn32); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op_load = 1'b0; size = '0; unsigned_ld = 1'b0;
        addr = '0; store_data = '0; resp_en = 1'b1; exp_ld = '0;
        st32 = 1'b0; ld32 = 1'b0; sz32 = '0; un32 = 1'b0; ad32 = '0; sd32 = '0;
        mif32.mem_ack = 1'b0; mif32.mem_rdata = '0;
        clear_mon();
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid();
        test_xlen32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1);
    end

endmodule
